// File: rtl/i2c_pkg.sv
// Shared constants and FSM state encoding for the accelerometer-style I2C target.
package i2c_pkg;

    localparam int unsigned REG_AW_DEF   = 6;
    localparam logic [6:0]  DEV_ADDR_DEF = 7'h53;
    localparam logic [7:0]  DEVID_VAL    = 8'hE5;
    localparam logic [7:0]  BW_RATE_RST  = 8'h0A;

    localparam logic [5:0] REG_DEVID       = 6'h00;
    localparam logic [5:0] REG_BW_RATE     = 6'h2C;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_DATAX0      = 6'h32;
    localparam logic [5:0] REG_DATAX1      = 6'h33;
    localparam logic [5:0] REG_DATAY0      = 6'h34;
    localparam logic [5:0] REG_DATAY1      = 6'h35;
    localparam logic [5:0] REG_DATAZ0      = 6'h36;
    localparam logic [5:0] REG_DATAZ1      = 6'h37;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_A_ACK,
        ST_WR_PTR,
        ST_WR_DATA,
        ST_W_ACK,
        ST_RD_BYTE,
        ST_M_ACK,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises raw SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_bus_monitor (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;
    logic       scl_s;

    // Two-stage synchroniser plus one history stage per line; idle bus is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s      = scl_sync[1];
    assign sda_s      = sda_sync[1];
    assign scl_rise_c = scl_s & ~scl_d;
    assign scl_fall_c = ~scl_s & scl_d;
    assign start_c    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target serving a 64-entry register map with pointer writes and auto-increment reads.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = DEV_ADDR_DEF,
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter logic [7:0]  DEVID_VAL = i2c_pkg::DEVID_VAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_valid,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data
);

    localparam int unsigned NUM_REGS = 2 ** REG_AW;

    logic sda_s;
    logic scl_rise_c;
    logic scl_fall_c;
    logic start_c;
    logic stop_c;

    i2c_bus_monitor u_mon (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_s      (sda_s),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              ack_q, ack_d;
    logic              rw_q, rw_d;
    logic              sda_oe_d;
    logic              busy_d;
    logic              wr_valid_d;
    logic [REG_AW-1:0] wr_addr_d;
    logic [7:0]        wr_data_d;
    logic              i2c_we_c;
    logic [7:0]        byte_in_c;
    logic [7:0]        rd_data_c;
    logic [7:0]        regs [NUM_REGS];

    assign byte_in_c = {shreg_q[6:0], sda_s};
    assign rd_data_c = regs[ptr_q];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd7;
            shreg_q   <= 8'h00;
            ptr_q     <= '0;
            ack_q     <= 1'b0;
            rw_q      <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            rw_q      <= rw_d;
            sda_oe    <= sda_oe_d;
            busy      <= busy_d;
            wr_valid  <= wr_valid_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
        end
    end

    // Protocol FSM: shifts on SCL rise, changes SDA drive on SCL fall; ack_q marks the second half of ACK slots.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ptr_d      = ptr_q;
        ack_d      = ack_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe;
        busy_d     = busy;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        i2c_we_c   = 1'b0;

        if (stop_c) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            ack_d    = 1'b0;
        end else if (start_c) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd7;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            ack_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise_c) begin
                        shreg_d   = byte_in_c;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            if (byte_in_c[7:1] == DEV_ADDR) begin
                                state_d = ST_A_ACK;
                                rw_d    = byte_in_c[0];
                                busy_d  = 1'b1;
                                ack_d   = 1'b0;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_A_ACK: begin
                    if (scl_fall_c) begin
                        if (!ack_q) begin
                            sda_oe_d = 1'b1;
                            ack_d    = 1'b1;
                        end else begin
                            ack_d     = 1'b0;
                            bit_cnt_d = 3'd7;
                            if (rw_q) begin
                                shreg_d  = rd_data_c;
                                sda_oe_d = ~rd_data_c[7];
                                state_d  = ST_RD_BYTE;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_WR_PTR;
                            end
                        end
                    end
                end
                ST_WR_PTR: begin
                    if (scl_rise_c) begin
                        shreg_d   = byte_in_c;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            ptr_d   = byte_in_c[REG_AW-1:0];
                            state_d = ST_W_ACK;
                            ack_d   = 1'b0;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise_c) begin
                        shreg_d   = byte_in_c;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            // DEVID is read-only: the byte is ACKed but not stored or reported.
                            if (ptr_q != '0) begin
                                i2c_we_c   = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = byte_in_c;
                            end
                            ptr_d   = ptr_q + REG_AW'(1);
                            state_d = ST_W_ACK;
                            ack_d   = 1'b0;
                        end
                    end
                end
                ST_W_ACK: begin
                    if (scl_fall_c) begin
                        if (!ack_q) begin
                            sda_oe_d = 1'b1;
                            ack_d    = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            ack_d     = 1'b0;
                            bit_cnt_d = 3'd7;
                            state_d   = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall_c) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + REG_AW'(1);
                            ack_d    = 1'b0;
                            state_d  = ST_M_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            sda_oe_d  = ~shreg_q[bit_cnt_q - 3'd1];
                        end
                    end
                end
                ST_M_ACK: begin
                    if (scl_rise_c) begin
                        if (!sda_s) begin
                            ack_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall_c && ack_q) begin
                        ack_d     = 1'b0;
                        shreg_d   = rd_data_c;
                        bit_cnt_d = 3'd7;
                        sda_oe_d  = ~rd_data_c[7];
                        state_d   = ST_RD_BYTE;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Register file: I2C write beats a user load to the same address; DEVID never changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
            regs[REG_AW'(REG_DEVID)]   <= DEVID_VAL;
            regs[REG_AW'(REG_BW_RATE)] <= BW_RATE_RST;
        end else begin
            if (i2c_we_c) begin
                regs[ptr_q] <= byte_in_c;
            end
            if (ld_en && (ld_addr != REG_AW'(REG_DEVID)) && !(i2c_we_c && (ld_addr == ptr_q))) begin
                regs[ld_addr] <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: open-drain bus master plus a register-map reference model.
module tb_i2c_target_regfile;

    // SCL quarter period in system clocks (SCL high and low phases are 2*Q each).
    localparam int unsigned Q      = 8;
    localparam logic [7:0]  ADDR_W = 8'hA6;
    localparam logic [7:0]  ADDR_R = 8'hA7;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    logic       ld_en   = 1'b0;
    logic [5:0] ld_addr = 6'h00;
    logic [7:0] ld_data = 8'h00;
    logic       sda_line;
    logic       sda_oe;
    logic       busy;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    assign sda_line = ~(m_low | sda_oe);

    i2c_target_regfile dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    always #10 clk = ~clk;

    // Observed write strobes and SDA drive activity.
    logic [13:0] wr_log [$];
    int unsigned oe_cycles = 0;
    always @(negedge clk) begin
        if (wr_valid) wr_log.push_back({wr_addr, wr_data});
        if (sda_oe) oe_cycles++;
    end

    // Reference model state.
    logic [7:0]  m_regs [64];
    logic [5:0]  m_ptr;
    logic [13:0] exp_wr [$];
    logic [7:0]  wbuf [$];
    int          wr_seen = 0;
    logic [5:0]  col_addr;
    logic [7:0]  col_data;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
        m_regs[0]     = 8'hE5;
        m_regs[6'h2C] = 8'h0A;
        m_ptr         = 6'h00;
    endtask

    task automatic load_reg(input logic [5:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick(1);
        ld_en   = 1'b0;
        if (a != 6'h00) m_regs[a] = d;
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(2 * Q);
        m_low = 1'b1;
        tick(2 * Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(2 * Q);
        m_low = 1'b0;
        tick(4 * Q);
    endtask

    // One SCL period; col fires a user load to col_addr in the cycle the target commits the byte.
    task automatic clock_bit(input logic b, input logic col, output logic s);
        m_low = ~b;
        tick(Q);
        scl = 1'b1;
        if (col) begin
            tick(2);
            ld_en   = 1'b1;
            ld_addr = col_addr;
            ld_data = col_data;
            tick(1);
            ld_en   = 1'b0;
            tick(Q - 3);
        end else begin
            tick(Q);
        end
        s = sda_line;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic col, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], col && (i == 0), s);
        clock_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, 1'b0, s);
            d = {d[6:0], s};
        end
        clock_bit(nack, 1'b0, s);
    endtask

    task automatic check_wr_log(input string tag);
        int got_n;
        got_n = wr_log.size() - wr_seen;
        check({tag, "_count"}, 32'(got_n), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_n; i++)
            check(tag, 32'(wr_log[wr_seen + i]), 32'(exp_wr[i]));
        wr_seen = wr_log.size();
        exp_wr.delete();
    endtask

    task automatic do_write(input logic [5:0] p, input logic col);
        logic ok;
        bus_start();
        write_byte(ADDR_W, 1'b0, ok);
        check("w_addr_ack", 32'(ok), 32'd1);
        write_byte({2'b00, p}, 1'b0, ok);
        check("w_ptr_ack", 32'(ok), 32'd1);
        m_ptr = p;
        for (int i = 0; i < wbuf.size(); i++) begin
            col_addr = m_ptr;
            write_byte(wbuf[i], col && (i == 0), ok);
            check("w_data_ack", 32'(ok), 32'd1);
            if (m_ptr != 6'h00) begin
                m_regs[m_ptr] = wbuf[i];
                exp_wr.push_back({m_ptr, wbuf[i]});
            end
            m_ptr = m_ptr + 6'd1;
        end
        check("w_busy", 32'(busy), 32'd1);
        bus_stop();
        check("w_busy_stop", 32'(busy), 32'd0);
        check_wr_log("w_log");
        wbuf.delete();
    endtask

    task automatic do_read(input logic set_ptr, input logic [5:0] p, input int n);
        logic       ok;
        logic [7:0] d;
        if (set_ptr) begin
            bus_start();
            write_byte(ADDR_W, 1'b0, ok);
            check("r_waddr_ack", 32'(ok), 32'd1);
            write_byte({2'b00, p}, 1'b0, ok);
            check("r_ptr_ack", 32'(ok), 32'd1);
            m_ptr = p;
        end
        bus_start();
        write_byte(ADDR_R, 1'b0, ok);
        check("r_addr_ack", 32'(ok), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check($sformatf("r_data[%0h]", m_ptr), 32'(d), 32'(m_regs[m_ptr]));
            m_ptr = m_ptr + 6'd1;
        end
        check("r_busy", 32'(busy), 32'd1);
        bus_stop();
        check("r_busy_stop", 32'(busy), 32'd0);
    endtask

    initial begin
        logic       ok;
        logic       s;
        logic [7:0] r;
        int unsigned snap_oe;

        model_reset();
        tick(5);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        reset = 1'b0;
        tick(5);

        // Pointer + data write, then read it back.
        wbuf.push_back(8'h0B);
        do_write(6'h31, 1'b0);
        do_read(1'b1, 6'h31, 1);

        // DEVID read via repeated START.
        do_read(1'b1, 6'h00, 1);

        // Sample registers loaded by user logic, burst read, then continue from the pointer.
        for (int i = 0; i < 6; i++) load_reg(6'h32 + 6'(i), 8'(8'h11 * (i + 1)));
        load_reg(6'h38, 8'h77);
        do_read(1'b1, 6'h32, 6);
        do_read(1'b0, 6'h00, 1);

        // Foreign address is ignored completely.
        snap_oe = oe_cycles;
        bus_start();
        write_byte(8'hA8, 1'b0, ok);
        check("bad_addr_ack", 32'(ok), 32'd0);
        write_byte(8'h31, 1'b0, ok);
        check("bad_data_ack", 32'(ok), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        bus_stop();
        check("bad_oe_cycles", oe_cycles - snap_oe, 32'd0);
        check_wr_log("bad_log");
        wbuf.push_back(8'($urandom));
        do_write(6'h05, 1'b0);
        do_read(1'b1, 6'h05, 1);

        // Pointer wrap 0x3F -> 0x00 with DEVID write dropped.
        load_reg(6'h01, 8'h5A);
        wbuf.push_back(8'hAA);
        wbuf.push_back(8'hBB);
        do_write(6'h3F, 1'b0);
        do_read(1'b0, 6'h00, 1);
        do_read(1'b1, 6'h3F, 2);

        // User load colliding with an I2C write to the same register.
        col_data = 8'hC3;
        wbuf.push_back(8'h3C);
        do_write(6'h0C, 1'b1);
        do_read(1'b1, 6'h0C, 1);

        // Reset while the target is driving a 0 data bit.
        load_reg(6'h10, 8'h05);
        bus_start();
        write_byte(ADDR_W, 1'b0, ok);
        write_byte(8'h10, 1'b0, ok);
        bus_start();
        write_byte(ADDR_R, 1'b0, ok);
        check("rd_addr_ack", 32'(ok), 32'd1);
        check("rd_drive_oe", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_oe", 32'(sda_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick(2);
        reset = 1'b0;
        model_reset();
        bus_stop();
        do_read(1'b1, 6'h31, 1);
        do_read(1'b1, 6'h2C, 1);

        // STOP in the middle of a data byte.
        r = 8'($urandom);
        load_reg(6'h20, r);
        bus_start();
        write_byte(ADDR_W, 1'b0, ok);
        check("ms_addr_ack", 32'(ok), 32'd1);
        write_byte(8'h20, 1'b0, ok);
        check("ms_ptr_ack", 32'(ok), 32'd1);
        m_ptr = 6'h20;
        for (int i = 0; i < 4; i++) clock_bit(1'b0, 1'b0, s);
        bus_stop();
        check("ms_busy", 32'(busy), 32'd0);
        check_wr_log("ms_log");
        do_read(1'b0, 6'h00, 1);

        // Random mix of writes, reads and user loads.
        for (int k = 0; k < 12; k++) begin
            int unsigned op;
            int          n;
            logic [5:0]  p;
            op = $urandom_range(0, 2);
            n  = int'($urandom_range(1, 3));
            p  = 6'($urandom_range(0, 63));
            if (op == 0) begin
                for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
                do_write(p, 1'b0);
            end else if (op == 1) begin
                do_read(1'b1, p, n);
            end else begin
                load_reg(p, 8'($urandom));
            end
        end

        // Full register map sweep.
        do_read(1'b1, 6'h00, 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
